mult_resp_pipe: RTL and testbench

- Pipelined multiplier responder: the server side of the multiplier-request stream that modular-reduction blocks issue.
- Accepts requests of two packed DAT_BITS operands plus ctl, and returns the full 2*DAT_BITS product with ctl unchanged, in request order.
- Fixed-latency multiply pipeline that never stalls, followed by a credit-protected response FIFO, so downstream backpressure never loses data.
- One instance sits behind each requester multiplier port.

---
 rtl/mult_resp_pipe_pkg.sv | 18 +
 rtl/axi_stream_fifo.sv | 73 +++++++
 rtl/mult_resp_pipe.sv | 127 ++++++++++++
 tb/tb_mult_resp_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_resp_pipe_pkg.sv
// Shared types and helpers for the multiplier request/response stream.
// Requesters pack operands with mult_req_t; responders size credit counters with mult_resp_cnt_bits.
package mult_resp_pipe_pkg;

  localparam int MULT_DAT_BITS = 381;

  // Request payload as it sits on i_req_dat: b in the upper half, a in the lower half.
  typedef struct packed {
    logic [MULT_DAT_BITS-1:0] b;
    logic [MULT_DAT_BITS-1:0] a;
  } mult_req_t;

  // Counter must reach FIFO_DEPTH inclusive.
  function automatic int mult_resp_cnt_bits(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

endpackage

// File: rtl/axi_stream_fifo.sv
// Small synchronous FIFO with flop-based storage; head entry is read straight from the flops.
// Writes while full are dropped; the owner is expected to prevent them with credits.
module axi_stream_fifo #(
  parameter int SIZE     = 8,
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_val,
  input  logic [DAT_BITS-1:0] i_dat,
  input  logic [CTL_BITS-1:0] i_ctl,
  output logic                o_full,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic [CTL_BITS-1:0] o_ctl
);

  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [DAT_BITS-1:0] dat_mem [SIZE];
  logic [CTL_BITS-1:0] ctl_mem [SIZE];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full = (cnt_q == CNT_W'(SIZE));
  assign o_val  = (cnt_q != '0);
  assign o_dat  = dat_mem[rd_ptr_q];
  assign o_ctl  = ctl_mem[rd_ptr_q];

  assign wr_en = i_val && !o_full;
  assign rd_en = o_val && i_rdy;

  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      dat_mem[wr_ptr_q] <= i_dat;
      ctl_mem[wr_ptr_q] <= i_ctl;
    end
  end

endmodule

// File: rtl/mult_resp_pipe.sv
// Multiplier responder: fixed-latency, never-stalling multiply pipeline feeding a response FIFO.
// A credit counter covering pipeline + FIFO gates o_req_rdy so the FIFO can never overflow.
module mult_resp_pipe
  import mult_resp_pipe_pkg::*;
#(
  parameter int DAT_BITS   = 381,
  parameter int CTL_BITS   = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_val,
  output logic                  o_req_rdy,
  input  logic [2*DAT_BITS-1:0] i_req_dat,
  input  logic [CTL_BITS-1:0]   i_req_ctl,
  output logic                  o_rsp_val,
  input  logic                  i_rsp_rdy,
  output logic [2*DAT_BITS-1:0] o_rsp_dat,
  output logic [CTL_BITS-1:0]   o_rsp_ctl,
  output logic                  o_rsp_sop,
  output logic                  o_rsp_eop,
  output logic                  o_err
);

  localparam int PW    = 2 * DAT_BITS;
  localparam int CNT_W = mult_resp_cnt_bits(FIFO_DEPTH);

  if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 1) begin : g_bad_cfg
    $error("mult_resp_pipe: requires LATENCY >= 1 and FIFO_DEPTH >= LATENCY+1");
  end

  typedef struct packed {
    logic [DAT_BITS-1:0] b;
    logic [DAT_BITS-1:0] a;
  } req_t;

  req_t req;
  assign req = i_req_dat;

  logic             req_fire, rsp_fire, rsp_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Ready depends only on the credit register, never on i_rsp_rdy.
  assign o_req_rdy = !i_rst && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign req_fire  = i_req_val && o_req_rdy;
  assign rsp_fire  = rsp_val && i_rsp_rdy;

  always_comb begin
    cnt_d = cnt_q;
    case ({req_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  logic [LATENCY-1:0]  vld_pipe;
  logic [CTL_BITS-1:0] ctl_pipe [LATENCY];
  logic [DAT_BITS-1:0] a_q, b_q;
  logic [PW-1:0]       last_prod;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= req_fire;
      for (int s = 1; s < LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    a_q         <= req.a;
    b_q         <= req.b;
    ctl_pipe[0] <= i_req_ctl;
    for (int s = 1; s < LATENCY; s++) ctl_pipe[s] <= ctl_pipe[s-1];
  end

  // Single-stage build multiplies straight out of the operand registers.
  if (LATENCY == 1) begin : g_lat1
    assign last_prod = PW'(a_q) * PW'(b_q);
  end else begin : g_latn
    logic [PW-1:0] prod_q [1:LATENCY-1];
    always_ff @(posedge i_clk) begin
      prod_q[1] <= PW'(a_q) * PW'(b_q);
      for (int s = 2; s < LATENCY; s++) prod_q[s] <= prod_q[s-1];
    end
    assign last_prod = prod_q[LATENCY-1];
  end

  logic fifo_full;

  axi_stream_fifo #(
    .SIZE     (FIFO_DEPTH),
    .DAT_BITS (PW),
    .CTL_BITS (CTL_BITS)
  ) u_rsp_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_val  (vld_pipe[LATENCY-1]),
    .i_dat  (last_prod),
    .i_ctl  (ctl_pipe[LATENCY-1]),
    .o_full (fifo_full),
    .o_val  (rsp_val),
    .i_rdy  (i_rsp_rdy),
    .o_dat  (o_rsp_dat),
    .o_ctl  (o_rsp_ctl)
  );

  // Overflow should be unreachable under the credit scheme; flag it if it ever happens.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                 err_q <= 1'b0;
    else if (vld_pipe[LATENCY-1] && fifo_full) err_q <= 1'b1;
  end

  assign o_rsp_val = rsp_val;
  assign o_rsp_sop = 1'b1;
  assign o_rsp_eop = 1'b1;
  assign o_err     = err_q;

endmodule

// File: tb/tb_mult_resp_pipe.sv
// Bench for mult_resp_pipe at DAT_BITS=8: vector table, corner sequences, random traffic vs scoreboard.
module tb_mult_resp_pipe;

  localparam int DW = 8, CW = 8, LAT = 3, DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_val = 1'b0;
  logic            o_req_rdy;
  logic [2*DW-1:0] req_dat = '0;
  logic [CW-1:0]   req_ctl = '0;
  logic            o_rsp_val;
  logic            rsp_rdy = 1'b0;
  logic [2*DW-1:0] o_rsp_dat;
  logic [CW-1:0]   o_rsp_ctl;
  logic            o_rsp_sop, o_rsp_eop, o_err;

  always #5 clk = ~clk;

  mult_resp_pipe #(.DAT_BITS(DW), .CTL_BITS(CW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(req_val), .o_req_rdy(o_req_rdy), .i_req_dat(req_dat), .i_req_ctl(req_ctl),
    .o_rsp_val(o_rsp_val), .i_rsp_rdy(rsp_rdy), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl),
    .o_rsp_sop(o_rsp_sop), .o_rsp_eop(o_rsp_eop), .o_err(o_err)
  );

  int n_vec = 0, n_err = 0, n_req = 0, n_rsp = 0, cyc = 0;
  logic [2*DW+CW-1:0] sb [$];
  logic [2*DW-1:0]    cur_exp = '0;
  logic               hold = 1'b0;
  logic [2*DW-1:0]    held_dat;
  logic [CW-1:0]      held_ctl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push on request accept, pop and compare on response accept.
  always @(negedge clk) begin
    logic [2*DW+CW-1:0] e;
    if (rst) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("rsp_hold_val", o_rsp_val, 1);
        chk("rsp_hold_dat", {o_rsp_ctl, o_rsp_dat}, {held_ctl, held_dat});
      end
      if (req_val && o_req_rdy) begin
        sb.push_back({cur_exp, req_ctl});
        n_req++;
      end
      if (o_rsp_val && rsp_rdy) begin
        n_rsp++;
        if (sb.size() == 0) fail("rsp_unexpected");
        else begin
          e = sb.pop_front();
          chk("rsp_dat", o_rsp_dat, e[2*DW+CW-1:CW]);
          chk("rsp_ctl", o_rsp_ctl, e[CW-1:0]);
          chk("rsp_sop_eop", {o_rsp_sop, o_rsp_eop}, 2'b11);
        end
      end
      hold     = o_rsp_val && !rsp_rdy;
      held_dat = o_rsp_dat;
      held_ctl = o_rsp_ctl;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] ctl,
                      input logic [2*DW-1:0] exp, output int waits);
    req_dat = {b, a};
    req_ctl = ctl;
    cur_exp = exp;
    req_val = 1'b1;
    waits   = 0;
    @(negedge clk);
    while (!o_req_rdy && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!o_req_rdy) fail("send_timeout");
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic offer(input int k);
    req_dat = {8'(k + 1), 8'(k)};
    req_ctl = 8'(k);
    cur_exp = 16'(k * (k + 1));
    req_val = 1'b1;
  endtask

  task automatic check_single(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] ctl,
                              input logic [2*DW-1:0] exp, input string nm);
    int w, lat;
    lat = 0;
    send(a, b, ctl, exp, w);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_rsp_val) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) fail($sformatf("%s_timeout", nm));
    else begin
      chk($sformatf("%s_lat", nm), lat, LAT + 1);
      chk($sformatf("%s_dat", nm), o_rsp_dat, exp);
      chk($sformatf("%s_ctl", nm), o_rsp_ctl, ctl);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [DW-1:0]   a, b;
    logic [CW-1:0]   ctl;
    logic [2*DW-1:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int   w, k, t, drops, c0, c1, base, n8, base_q, base_r;
    logic [DW-1:0] ra, rb;

    tbl[0] = '{a: 8'hFF, b: 8'hFF, ctl: 8'h5A, exp: 16'hFE01};
    tbl[1] = '{a: 8'h00, b: 8'hC3, ctl: 8'h01, exp: 16'h0000};
    tbl[2] = '{a: 8'h01, b: 8'hFF, ctl: 8'h02, exp: 16'h00FF};
    tbl[3] = '{a: 8'h80, b: 8'h80, ctl: 8'h03, exp: 16'h4000};
    tbl[4] = '{a: 8'h10, b: 8'h0F, ctl: 8'hA5, exp: 16'h00F0};
    tbl[5] = '{a: 8'hFE, b: 8'h02, ctl: 8'hFF, exp: 16'h01FC};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_val", o_rsp_val, 0);
    chk("rst_req_rdy", o_req_rdy, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", o_req_rdy, 1);
    chk("post_rst_val", o_rsp_val, 0);
    @(posedge clk); #1;

    // Table vectors with latency check
    rsp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) check_single(tbl[i].a, tbl[i].b, tbl[i].ctl, tbl[i].exp, $sformatf("tbl%0d", i));

    // Back-to-back stream of 20
    drops = 0;
    base  = n_rsp;
    c0    = 0;
    c1    = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(8'(i), 8'(i + 1), 8'(i), 16'(i * (i + 1)), w);
          drops += w;
        end
      end
      begin
        int tt;
        tt = 0;
        while (n_rsp == base && tt < 60) begin @(posedge clk); #1; tt++; end
        c0 = cyc;
        while (n_rsp < base + 20 && tt < 120) begin @(posedge clk); #1; tt++; end
        c1 = cyc;
        if (n_rsp < base + 20) fail("stream_timeout");
      end
    join
    chk("stream_rdy_drops", drops, 0);
    chk("stream_span", c1 - c0, 19);

    // Backpressure fill: exactly DEPTH accepts
    rsp_rdy = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      offer(k);
      @(negedge clk);
      if (o_req_rdy) k++;
      @(posedge clk); #1;
    end
    chk("fill_accepts", k, DEPTH);
    @(negedge clk);
    chk("fill_rdy_low", o_req_rdy, 0);
    chk("fill_rsp_val", o_rsp_val, 1);
    @(posedge clk); #1;

    // Full credit: response frees a slot, then balanced traffic holds the count
    rsp_rdy = 1'b1;
    offer(k);
    @(negedge clk);
    chk("full_rdy", o_req_rdy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy_after_rsp", o_req_rdy, 1);
    if (o_req_rdy) k++;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      offer(k);
      @(negedge clk);
      chk("rdy_steady", o_req_rdy, 1);
      if (o_req_rdy) k++;
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b0;
    offer(k);
    @(negedge clk);
    chk("rdy_before_refill", o_req_rdy, 1);
    @(posedge clk); #1;
    req_val = 1'b0;
    @(negedge clk);
    chk("rdy_refull", o_req_rdy, 0);
    @(posedge clk); #1;

    // Drain: one response per cycle
    repeat (5) begin @(posedge clk); #1; end
    chk("drain_sb", sb.size(), DEPTH);
    n8   = sb.size();
    base = n_rsp;
    rsp_rdy = 1'b1;
    t = 0;
    while (n_rsp < base + n8 && t < 40) begin @(posedge clk); #1; t++; end
    chk("drain_span", t, DEPTH);
    chk("bp_err", o_err, 0);

    // Reset with 3 in pipeline and 4 in FIFO
    rsp_rdy = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(i + 1), 8'(i + 2), 8'(8'h40 + i), 16'((i + 1) * (i + 2)), w);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pre_val", o_rsp_val, 1);
    chk("rst_mid_rdy", o_req_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_val", o_rsp_val, 0);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    check_single(8'h03, 8'h07, 8'h77, 16'h0015, "post_rst");
    repeat (6) begin @(posedge clk); #1; end
    chk("post_rst_sb", sb.size(), 0);

    // Random traffic on both sides
    base_q = n_req;
    base_r = n_rsp;
    t = 0;
    while (t < 60000) begin
      if (n_req - base_q >= 10000 && sb.size() == 0) break;
      rsp_rdy = ($urandom_range(0, 3) != 0);
      if (n_req - base_q < 10000) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        req_dat = {rb, ra};
        req_ctl = 8'($urandom_range(0, 255));
        cur_exp = 16'(ra) * 16'(rb);
        req_val = ($urandom_range(0, 3) != 0);
      end else begin
        req_val = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    chk("rand_req", n_req - base_q, 10000);
    chk("rand_rsp", n_rsp - base_r, 10000);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_err", o_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
